ifid_ctrl: RTL and testbench

IFID_CTRL -- requirements
Module: ifid_ctrl

---
 rtl/ifid_ctrl_pkg.sv | 42 ++++
 rtl/ifid_ctrl_hazard_detect.sv | 16 +
 rtl/ifid_ctrl.sv | 136 +++++++++++++
 tb/tb_ifid_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_ctrl_pkg.sv
// Shared pipeline definitions: IF/ID control FSM encoding, register/NOP constants
// and the control-output bundle used by the IF/ID hazard controller.
package ifid_ctrl_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ST_W    = 2;

  localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
  localparam logic [ST_W-1:0] ST_MISS   = 2'd1;
  localparam logic [ST_W-1:0] ST_REPLAY = 2'd2;
  localparam logic [ST_W-1:0] ST_ERROR  = 2'd3;

  localparam logic [REG_W-1:0]   ZERO_REG  = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic refill_req;
  } pipe_ctrl_t;

  // Frozen front end: nothing advances, ID/EX gets a NOP so ID is not issued twice.
  function automatic pipe_ctrl_t ctrl_stall();
    pipe_ctrl_t c;
    c             = '0;
    c.idex_bubble = 1'b1;
    return c;
  endfunction

  // Normal advance of PC and IF/ID.
  function automatic pipe_ctrl_t ctrl_advance();
    pipe_ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.ifid_write = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ifid_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources in IF/ID.
module hazard_detect
  import ifid_ctrl_pkg::*;
(
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             load_use_c
);

  // A load into the zero register never creates a dependency.
  assign load_use_c = idex_memread && (idex_rt != ZERO_REG) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/ifid_ctrl.sv
// IF/ID pipeline controller: branch flush, I-cache miss/refill sequencing with
// timeout, load-use stalls and a saturating stall-cycle counter.
module ifid_ctrl
  import ifid_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned REFILL_MAX = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             icache_hit,
  input  logic             refill_ack,
  input  logic             branch_taken,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             refill_req,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned RC_W = $clog2(REFILL_MAX + 1);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic [RC_W-1:0]  rc_q;
  logic             flush_pend_q;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic             load_use_c;
  pipe_ctrl_t       ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use_c   (load_use_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs; RUN priority is branch > miss > load-use.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          ctrl            = ctrl_advance();
          ctrl.ifid_flush = 1'b1;
        end else if (!icache_hit) begin
          ctrl    = ctrl_stall();
          state_d = ST_MISS;
        end else if (load_use_c) begin
          ctrl = ctrl_stall();
        end else begin
          ctrl            = ctrl_advance();
          ctrl.ifid_flush = flush_pend_q;
        end
      end
      ST_MISS: begin
        ctrl            = ctrl_stall();
        ctrl.refill_req = 1'b1;
        if (refill_ack) begin
          state_d = ST_REPLAY;
        end else if (rc_q == RC_W'(REFILL_MAX - 1)) begin
          state_d = ST_ERROR;
        end
      end
      ST_REPLAY: begin
        ctrl    = ctrl_stall();
        state_d = ST_RUN;
      end
      ST_ERROR: begin
        ctrl = ctrl_stall();
      end
      default: begin
        ctrl    = ctrl_stall();
        state_d = ST_RUN;
      end
    endcase
  end

  // A flush owed from a branch seen while stalled survives until the next RUN cycle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rc_q         <= '0;
      flush_pend_q <= 1'b0;
      timeout_q    <= 1'b0;
      stall_q      <= '0;
    end else begin
      if ((state_q != ST_MISS) && (state_d == ST_MISS)) begin
        rc_q <= '0;
      end else if (state_q == ST_MISS) begin
        rc_q <= rc_q + RC_W'(1);
      end

      if (state_q == ST_RUN) begin
        flush_pend_q <= 1'b0;
      end else if (((state_q == ST_MISS) || (state_q == ST_REPLAY)) && branch_taken) begin
        flush_pend_q <= 1'b1;
      end

      if (state_d == ST_ERROR) begin
        timeout_q <= 1'b1;
      end

      if (!ctrl.pc_write && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // Reset forces the pipeline safe regardless of the clock.
  assign pc_write     = ~rstn & ctrl.pc_write;
  assign ifid_write   = ~rstn & ctrl.ifid_write;
  assign ifid_flush   =  rstn | ctrl.ifid_flush;
  assign idex_bubble  =  rstn | ctrl.idex_bubble;
  assign refill_req   = ~rstn & ctrl.refill_req;
  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ifid_ctrl.sv
// Directed testbench for ifid_ctrl; stall counter narrowed to 4 bits to reach saturation.
module tb_ifid_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rstn;
  logic             icache_hit;
  logic             refill_ack;
  logic             branch_taken;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             refill_req;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  ifid_ctrl #(.CNT_W(CNT_W), .REFILL_MAX(15)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .icache_hit   (icache_hit),
    .refill_ack   (refill_ack),
    .branch_taken (branch_taken),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .refill_req   (refill_req),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    icache_hit   = 1'b1;
    refill_ack   = 1'b0;
    branch_taken = 1'b0;
    idex_memread = 1'b0;
    idex_rt      = 5'd0;
    ifid_rs      = 5'd0;
    ifid_rt      = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b0) $display("FAIL rst_pc_write act=%b exp=0", pc_write); else n_pass++;
    n_chk++; if (ifid_write !== 1'b0) $display("FAIL rst_ifid_write act=%b exp=0", ifid_write); else n_pass++;
    n_chk++; if (ifid_flush !== 1'b1) $display("FAIL rst_ifid_flush act=%b exp=1", ifid_flush); else n_pass++;
    n_chk++; if (idex_bubble !== 1'b1) $display("FAIL rst_idex_bubble act=%b exp=1", idex_bubble); else n_pass++;
    n_chk++; if (refill_req !== 1'b0) $display("FAIL rst_refill_req act=%b exp=0", refill_req); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout act=%b exp=0", timeout_err); else n_pass++;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b1) $display("FAIL run_pc_write act=%b exp=1", pc_write); else n_pass++;
    n_chk++; if (ifid_write !== 1'b1) $display("FAIL run_ifid_write act=%b exp=1", ifid_write); else n_pass++;
    n_chk++; if (ifid_flush !== 1'b0) $display("FAIL run_ifid_flush act=%b exp=0", ifid_flush); else n_pass++;
    n_chk++; if (idex_bubble !== 1'b0) $display("FAIL run_idex_bubble act=%b exp=0", idex_bubble); else n_pass++;
    n_chk++; if (stall_cycles !== 4'd0) $display("FAIL run_stall act=%0d exp=0", stall_cycles); else n_pass++;
  endtask

  task automatic test_miss_refill();
    int req_hi;
    int pc_hi;
    req_hi = 0;
    pc_hi  = 0;
    do_reset();
    icache_hit = 1'b0;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b0) $display("FAIL miss_t0_pc_write act=%b exp=0", pc_write); else n_pass++;
    n_chk++; if (refill_req !== 1'b0) $display("FAIL miss_t0_refill_req act=%b exp=0", refill_req); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      icache_hit = 1'b1;
      refill_ack = (k == 2);
      @(negedge clk);
      if (refill_req === 1'b1) req_hi++;
      if (pc_write !== 1'b0) pc_hi++;
    end
    n_chk++; if (req_hi != 3) $display("FAIL miss_req_cycles act=%0d exp=3", req_hi); else n_pass++;
    n_chk++; if (pc_hi != 0) $display("FAIL miss_pc_write_cycles act=%0d exp=0", pc_hi); else n_pass++;
    next_cycle();
    refill_ack = 1'b0;
    @(negedge clk);
    n_chk++; if (refill_req !== 1'b0) $display("FAIL replay_refill_req act=%b exp=0", refill_req); else n_pass++;
    n_chk++; if (pc_write !== 1'b0) $display("FAIL replay_pc_write act=%b exp=0", pc_write); else n_pass++;
    n_chk++; if (ifid_write !== 1'b0) $display("FAIL replay_ifid_write act=%b exp=0", ifid_write); else n_pass++;
    n_chk++; if (idex_bubble !== 1'b1) $display("FAIL replay_bubble act=%b exp=1", idex_bubble); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b1) $display("FAIL after_replay_pc_write act=%b exp=1", pc_write); else n_pass++;
    n_chk++; if (idex_bubble !== 1'b0) $display("FAIL after_replay_bubble act=%b exp=0", idex_bubble); else n_pass++;
    n_chk++; if (stall_cycles !== 4'd5) $display("FAIL miss_stall_count act=%0d exp=5", stall_cycles); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b0) $display("FAIL lu_rs_pc_write act=%b exp=0", pc_write); else n_pass++;
    n_chk++; if (ifid_write !== 1'b0) $display("FAIL lu_rs_ifid_write act=%b exp=0", ifid_write); else n_pass++;
    n_chk++; if (idex_bubble !== 1'b1) $display("FAIL lu_rs_bubble act=%b exp=1", idex_bubble); else n_pass++;
    next_cycle();
    idex_memread = 1'b0;
    @(negedge clk);
    n_chk++; if (idex_bubble !== 1'b0) $display("FAIL lu_one_cycle_bubble act=%b exp=0", idex_bubble); else n_pass++;
    next_cycle();
    idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b1) $display("FAIL lu_r0_pc_write act=%b exp=1", pc_write); else n_pass++;
    n_chk++; if (idex_bubble !== 1'b0) $display("FAIL lu_r0_bubble act=%b exp=0", idex_bubble); else n_pass++;
    next_cycle();
    idex_rt = 5'd5; ifid_rs = 5'd9; ifid_rt = 5'd5;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b0) $display("FAIL lu_rt_pc_write act=%b exp=0", pc_write); else n_pass++;
    next_cycle();
    idex_rt = 5'd6;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b1) $display("FAIL lu_nomatch_pc_write act=%b exp=1", pc_write); else n_pass++;
    n_chk++; if (stall_cycles !== 4'd2) $display("FAIL lu_stall_count act=%0d exp=2", stall_cycles); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1'b1; icache_hit = 1'b0;
    @(negedge clk);
    n_chk++; if (ifid_flush !== 1'b1) $display("FAIL br_flush act=%b exp=1", ifid_flush); else n_pass++;
    n_chk++; if (pc_write !== 1'b1) $display("FAIL br_pc_write act=%b exp=1", pc_write); else n_pass++;
    n_chk++; if (ifid_write !== 1'b1) $display("FAIL br_ifid_write act=%b exp=1", ifid_write); else n_pass++;
    next_cycle();
    branch_taken = 1'b0; icache_hit = 1'b1;
    @(negedge clk);
    n_chk++; if (refill_req !== 1'b0) $display("FAIL br_no_miss_req act=%b exp=0", refill_req); else n_pass++;
    n_chk++; if (pc_write !== 1'b1) $display("FAIL br_no_miss_pc act=%b exp=1", pc_write); else n_pass++;
    next_cycle();
    branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd4; ifid_rs = 5'd4;
    @(negedge clk);
    n_chk++; if (idex_bubble !== 1'b0) $display("FAIL br_over_lu_bubble act=%b exp=0", idex_bubble); else n_pass++;
  endtask

  task automatic test_pending_flush();
    do_reset();
    icache_hit = 1'b0;
    next_cycle();
    icache_hit = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    n_chk++; if (ifid_flush !== 1'b0) $display("FAIL pend_miss_flush act=%b exp=0", ifid_flush); else n_pass++;
    next_cycle();
    branch_taken = 1'b0; refill_ack = 1'b1;
    next_cycle();
    refill_ack = 1'b0;
    @(negedge clk);
    n_chk++; if (ifid_flush !== 1'b0) $display("FAIL pend_replay_flush act=%b exp=0", ifid_flush); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (ifid_flush !== 1'b1) $display("FAIL pend_run_flush act=%b exp=1", ifid_flush); else n_pass++;
    n_chk++; if (pc_write !== 1'b1) $display("FAIL pend_run_pc_write act=%b exp=1", pc_write); else n_pass++;
    next_cycle();
    refill_ack = 1'b1;
    @(negedge clk);
    n_chk++; if (ifid_flush !== 1'b0) $display("FAIL pend_cleared act=%b exp=0", ifid_flush); else n_pass++;
    next_cycle();
    refill_ack = 1'b0;
    @(negedge clk);
    n_chk++; if (idex_bubble !== 1'b0) $display("FAIL stray_ack_bubble act=%b exp=0", idex_bubble); else n_pass++;
    n_chk++; if (pc_write !== 1'b1) $display("FAIL stray_ack_pc_write act=%b exp=1", pc_write); else n_pass++;
  endtask

  task automatic test_timeout();
    int req_hi;
    req_hi = 0;
    do_reset();
    icache_hit = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      icache_hit = 1'b1;
      @(negedge clk);
      if (refill_req === 1'b1) req_hi++;
      if (k == 8) begin
        n_chk++; if (stall_cycles !== 4'd8) $display("FAIL to_mid_stall act=%0d exp=8", stall_cycles); else n_pass++;
      end
      if (k == 15) begin
        n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_early act=%b exp=0", timeout_err); else n_pass++;
      end
    end
    n_chk++; if (req_hi != 15) $display("FAIL to_req_cycles act=%0d exp=15", req_hi); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_flag act=%b exp=1", timeout_err); else n_pass++;
    n_chk++; if (refill_req !== 1'b0) $display("FAIL to_refill_req act=%b exp=0", refill_req); else n_pass++;
    n_chk++; if (pc_write !== 1'b0) $display("FAIL to_pc_write act=%b exp=0", pc_write); else n_pass++;
    n_chk++; if (stall_cycles !== 4'd15) $display("FAIL to_stall_sat act=%0d exp=15", stall_cycles); else n_pass++;
    refill_ack = 1'b1; branch_taken = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_sticky act=%b exp=1", timeout_err); else n_pass++;
    n_chk++; if (ifid_write !== 1'b0) $display("FAIL to_hold_ifid act=%b exp=0", ifid_write); else n_pass++;
    n_chk++; if (stall_cycles !== 4'd15) $display("FAIL to_stall_hold act=%0d exp=15", stall_cycles); else n_pass++;
    do_reset();
    @(negedge clk);
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_cleared act=%b exp=0", timeout_err); else n_pass++;
    n_chk++; if (pc_write !== 1'b1) $display("FAIL to_rerun_pc act=%b exp=1", pc_write); else n_pass++;
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    icache_hit = 1'b0;
    next_cycle();
    icache_hit = 1'b1;
    next_cycle();
    n_chk++; if (refill_req !== 1'b1) $display("FAIL mm_req_before act=%b exp=1", refill_req); else n_pass++;
    #2 rstn = 1'b1;
    #1;
    n_chk++; if (refill_req !== 1'b0) $display("FAIL mm_req_async act=%b exp=0", refill_req); else n_pass++;
    n_chk++; if (ifid_flush !== 1'b1) $display("FAIL mm_flush_async act=%b exp=1", ifid_flush); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    n_chk++; if (pc_write !== 1'b1) $display("FAIL mm_run_pc act=%b exp=1", pc_write); else n_pass++;
    n_chk++; if (refill_req !== 1'b0) $display("FAIL mm_run_req act=%b exp=0", refill_req); else n_pass++;
    n_chk++; if (stall_cycles !== 4'd0) $display("FAIL mm_stall_zero act=%0d exp=0", stall_cycles); else n_pass++;
  endtask

  initial begin
    rstn = 1'b1;
    idle_inputs();
    test_reset();
    test_miss_refill();
    test_load_use();
    test_branch();
    test_pending_flush();
    test_timeout();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
